// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared types, constants and prefix-cell helpers for the sequential Kogge-Stone adder
//
// Contents:
//   ksa_state_e  : controller states IDLE / RUN / DONE
//   KSA_WIDTH    : default operand and sum width
//   KSA_SLICE    : default bits added per RUN cycle
//   ksa_black    : black prefix cell, returns {group generate, group propagate}
//   ksa_grey     : grey prefix cell, returns group generate only
package ksa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ksa_state_e;

  localparam int KSA_WIDTH = 16;
  localparam int KSA_SLICE = 4;

  function automatic logic [1:0] ksa_black(input logic g_hi, input logic p_hi,
                                           input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  // Used once the lower group already reaches bit 0, where the group
  // propagate is never consumed again.
  function automatic logic ksa_grey(input logic g_hi, input logic p_hi,
                                    input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

endpackage

// File: rtl/ksa_slice.sv
// rtl/ksa_slice.sv - SLICE-bit Kogge-Stone prefix adder with carry-in
//
// Ports:
//   i_a, i_b   : slice operands
//   i_cin      : carry into bit 0
//   o_sum      : i_a + i_b + i_cin, modulo 2^SLICE
//   o_cout     : carry out of the top bit
//   o_msb_cin  : carry into the top bit (used for signed overflow)
module ksa_slice
  import ksa_pkg::*;
#(
  parameter int SLICE = KSA_SLICE
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_msb_cin
);

  localparam int STAGES = (SLICE > 1) ? $clog2(SLICE) : 0;

  logic [SLICE-1:0] w_p0;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_c;

  always_comb begin
    w_p0 = i_a ^ i_b;
    w_g  = i_a & i_b;
    // Fold the carry-in into bit 0 so every prefix that reaches bit 0
    // already is the true carry.
    w_g[0] = w_g[0] | (w_p0[0] & i_cin);
    w_p    = w_p0;

    // In-place prefix tree; walking i downwards means position i-d still
    // holds the previous stage's value when it is read.
    for (int s = 0; s < STAGES; s++) begin
      for (int i = SLICE - 1; i >= (1 << s); i--) begin
        if (i >= (2 << s)) begin
          {w_g[i], w_p[i]} = ksa_black(w_g[i], w_p[i], w_g[i-(1<<s)], w_p[i-(1<<s)]);
        end else begin
          w_g[i] = ksa_grey(w_g[i], w_p[i], w_g[i-(1<<s)]);
        end
      end
    end

    w_c[0] = i_cin;
    for (int i = 1; i < SLICE; i++) begin
      w_c[i] = w_g[i-1];
    end

    o_sum     = w_p0 ^ w_c;
    o_cout    = w_g[SLICE-1];
    o_msb_cin = w_c[SLICE-1];
  end

endmodule

// File: rtl/ksa_seq_adder.sv
// rtl/ksa_seq_adder.sv - sequential adder processing SLICE bits per cycle through one Kogge-Stone slice
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin            : operands and carry-in, latched at acceptance
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout, ovf       : a+b+cin, carry out, signed overflow; held outside updates
//   busy                 : high in RUN and DONE
module ksa_seq_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH,
  parameter int SLICE = KSA_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

  ksa_state_e       r_state;
  ksa_state_e       w_state_nxt;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_s_sum;
  logic             w_s_cout;
  logic             w_s_msb_cin;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_state == RUN) && (r_k == K_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)           w_state_nxt = RUN;
      RUN:     if (r_k == K_LAST)      w_state_nxt = DONE;
      DONE:    if (out_ready)          w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == RUN) || (r_state == DONE);
  end

  // Operand slice selection by the slice counter
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int j = 0; j < NSLICE; j++) begin
      if (r_k == CW'(j)) begin
        w_a_sl = r_a[j*SLICE +: SLICE];
        w_b_sl = r_b[j*SLICE +: SLICE];
      end
    end
  end

  // Result register with the current slice written into its own bits
  always_comb begin
    w_res_next = r_res;
    for (int j = 0; j < NSLICE; j++) begin
      if (r_k == CW'(j)) begin
        w_res_next[j*SLICE +: SLICE] = w_s_sum;
      end
    end
  end

  ksa_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .i_a      (w_a_sl),
    .i_b      (w_b_sl),
    .i_cin    (r_carry),
    .o_sum    (w_s_sum),
    .o_cout   (w_s_cout),
    .o_msb_cin(w_s_msb_cin)
  );

  // Datapath; visible outputs only change on the final slice so they stay
  // stable through IDLE, RUN and DONE backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_res   <= w_res_next;
      r_carry <= w_s_cout;
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_s_cout;
        r_ovf  <= w_s_msb_cin ^ w_s_cout;
      end else begin
        r_k <= r_k + CW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
